decode_stage: RTL

Decode stage of the pipelined Y86-64 processor, sitting directly downstream of fetch. It holds the F→D pipeline register, which captures fetch outputs each cycle under stall/bubble control. It contains the 15-entry register file and generates the register IDs the instruction needs (srcA, srcB, dstE, dstM). It produces forwarded operands valA and valB for the execute pipeline register.

---
 rtl/y86_pkg.sv | 47 ++++
 rtl/decode_stage_if.sv | 36 +++
 rtl/decode_stage_regfile.sv | 37 +++
 rtl/decode_stage.sv | 97 +++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: instruction codes, register IDs,
// status codes and the decode-stage pipeline register layout.
package y86_pkg;

  localparam logic [3:0] IHALT  = 4'h0;
  localparam logic [3:0] INOP   = 4'h1;
  localparam logic [3:0] IRRMOV = 4'h2;
  localparam logic [3:0] IIRMOV = 4'h3;
  localparam logic [3:0] IRMMOV = 4'h4;
  localparam logic [3:0] IMRMOV = 4'h5;
  localparam logic [3:0] IOPQ   = 4'h6;
  localparam logic [3:0] IJXX   = 4'h7;
  localparam logic [3:0] ICALL  = 4'h8;
  localparam logic [3:0] IRET   = 4'h9;
  localparam logic [3:0] IPUSH  = 4'hA;
  localparam logic [3:0] IPOP   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    stat_e       stat;
  } d_reg_t;

  // Memory errors dominate instruction errors, which dominate halt.
  function automatic stat_e fetch_stat(input logic hlt, input logic in_mem,
                                       input logic in_inst);
    if (in_mem)       return SADR;
    else if (in_inst) return SINS;
    else if (hlt)     return SHLT;
    else              return SAOK;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/decode/forwarding bundle around the decode stage; the pipeline side
// is the master, the decode stage is the slave.
interface decode_stage_if;

  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        f_hlt, f_in_mem, f_in_inst;
  logic        D_stall, D_bubble;
  logic [3:0]  e_dstE, M_dstE, m_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;

  logic [3:0]  D_icode, D_ifun;
  logic [63:0] D_valC;
  logic [2:0]  D_stat;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;

  modport master (
    output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    output f_hlt, f_in_mem, f_in_inst, D_stall, D_bubble,
    output e_dstE, e_valE, M_dstE, M_valE, m_dstM, m_valM,
    output W_dstE, W_dstM, W_valE, W_valM,
    input  D_icode, D_ifun, D_valC, D_stat,
    input  d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
  );

  modport slave (
    input  f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    input  f_hlt, f_in_mem, f_in_inst, D_stall, D_bubble,
    input  e_dstE, e_valE, M_dstE, M_valE, m_dstM, m_valM,
    input  W_dstE, W_dstM, W_valE, W_valM,
    output D_icode, D_ifun, D_valC, D_stat,
    output d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
  );

endinterface

// File: rtl/decode_stage_regfile.sv
// 15-entry, 64-bit Y86-64 register file: two combinational reads, two
// synchronous writes (M port wins on a same-register conflict).
module regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] rd_a,
  output logic [63:0] rd_b,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] regs [15];

  // The later non-blocking write to the same entry takes effect, giving M priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= val_e;
      if (dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (src_a != RNONE) rd_a = regs[src_a];
    if (src_b != RNONE) rd_b = regs[src_b];
  end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: F->D pipeline register, register ID generation,
// register file and the operand forwarding muxes.
module decode_stage
  import y86_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  decode_stage_if.slave bus
);

  localparam d_reg_t BUBBLE = '{icode: INOP, ifun: 4'h0, ra: RNONE, rb: RNONE,
                                valc: '0, valp: '0, stat: SAOK};

  d_reg_t      d_q;
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] rf_a, rf_b;

  always_ff @(posedge clk) begin
    if (rst)               d_q <= BUBBLE;
    else if (bus.D_stall)  d_q <= d_q;
    else if (bus.D_bubble) d_q <= BUBBLE;
    else d_q <= '{icode: bus.f_icode, ifun: bus.f_ifun, ra: bus.f_rA, rb: bus.f_rB,
                  valc: bus.f_valC, valp: bus.f_valP,
                  stat: fetch_stat(bus.f_hlt, bus.f_in_mem, bus.f_in_inst)};
  end

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_q.icode)
      IRRMOV: begin src_a = d_q.ra; dst_e = d_q.rb; end
      IIRMOV: dst_e = d_q.rb;
      IRMMOV: begin src_a = d_q.ra; src_b = d_q.rb; end
      IMRMOV: begin src_b = d_q.rb; dst_m = d_q.ra; end
      IOPQ:   begin src_a = d_q.ra; src_b = d_q.rb; dst_e = d_q.rb; end
      ICALL:  begin src_b = RRSP; dst_e = RRSP; end
      IRET:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
      IPUSH:  begin src_a = d_q.ra; src_b = RRSP; dst_e = RRSP; end
      IPOP:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = d_q.ra; end
      default: ;
    endcase
  end

  regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .src_a (src_a),
    .src_b (src_b),
    .rd_a  (rf_a),
    .rd_b  (rf_b),
    .dst_e (bus.W_dstE),
    .val_e (bus.W_valE),
    .dst_m (bus.W_dstM),
    .val_m (bus.W_valM)
  );

  // s != RNONE is checked first, so an RNONE destination can never match.
  function automatic logic [63:0] fwd(
    input logic [3:0] s, input logic [63:0] rf,
    input logic [3:0] e_d, input logic [63:0] e_v,
    input logic [3:0] m_d, input logic [63:0] m_v,
    input logic [3:0] mm_d, input logic [63:0] mm_v,
    input logic [3:0] wm_d, input logic [63:0] wm_v,
    input logic [3:0] we_d, input logic [63:0] we_v);
    if (s == RNONE)     return '0;
    else if (s == e_d)  return e_v;
    else if (s == m_d)  return m_v;
    else if (s == mm_d) return mm_v;
    else if (s == wm_d) return wm_v;
    else if (s == we_d) return we_v;
    else                return rf;
  endfunction

  always_comb begin
    bus.d_valB = fwd(src_b, rf_b, bus.e_dstE, bus.e_valE, bus.m_dstM, bus.m_valM,
                     bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM, bus.W_dstE, bus.W_valE);
    if (d_q.icode == ICALL || d_q.icode == IJXX)
      bus.d_valA = d_q.valp;
    else
      bus.d_valA = fwd(src_a, rf_a, bus.e_dstE, bus.e_valE, bus.m_dstM, bus.m_valM,
                       bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM, bus.W_dstE, bus.W_valE);
  end

  always_comb begin
    bus.D_icode = d_q.icode;
    bus.D_ifun  = d_q.ifun;
    bus.D_valC  = d_q.valc;
    bus.D_stat  = d_q.stat;
    bus.d_srcA  = src_a;
    bus.d_srcB  = src_b;
    bus.d_dstE  = dst_e;
    bus.d_dstM  = dst_m;
  end

endmodule
